uart_tx_frame_serializer: RTL and testbench

Parametrised UART transmit engine that turns a parallel word into a complete serial frame: start bit, configurable data length, optional parity, and one or two stop bits. Each frame's format is selected at run time. A one-entry holding buffer lets frames go out back-to-back with no idle gap. Bit timing comes from an external baud-tick enable. The block sits between the system register/FIFO side (valid/ready) and the UART TX pin, and replaces the separate serializer, parity and controller trio.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_parity_calc.sv | 24 ++
 rtl/uart_tx_frame_serializer.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_frame_serializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART TX types: FSM state encoding, line levels and the per-frame format
// record that is also used by the UART config register block.
package uart_tx_pkg;

    // Wide enough for DW_MAX up to 16.
    localparam int CFG_LEN_W = 5;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef struct packed {
        logic [CFG_LEN_W-1:0] len;
        logic                 par_en;
        logic                 par_odd;
        logic                 stop2;
        logic                 msb_first;
    } frame_cfg_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity over the low i_len bits of a word; bits at i_len and above
// are masked off. Shared between the TX engine and the RX checker.
module uart_parity_calc #(
    parameter int DW_MAX = 8,
    parameter int LEN_W  = $clog2(DW_MAX + 1)
) (
    input  logic [DW_MAX-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_odd,
    output logic              o_parity
);

    logic [DW_MAX-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DW_MAX; i++) begin
            w_mask[i] = (LEN_W'(i) < i_len);
        end
    end

    assign o_parity = (^(i_data & w_mask)) ^ i_odd;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit engine: one-entry holding buffer feeding a frame FSM that emits
// start, data, optional parity and one or two stop bits on BAUD_EN ticks.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered frame
// START  | driving the start bit
// DATA   | driving data bit r_bit_cnt (order set by msb_first)
// PARITY | driving the parity bit
// STOP   | driving stop bit(s); may launch the next buffered frame directly
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int DW_MAX = 8,
    parameter int LEN_W  = $clog2(DW_MAX + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BAUD_EN,
    input  logic [DW_MAX-1:0] P_DATA,
    input  logic              DATA_VALID,
    output logic              DATA_READY,
    input  logic [LEN_W-1:0]  CFG_LEN,
    input  logic              CFG_PAR_EN,
    input  logic              CFG_PAR_ODD,
    input  logic              CFG_STOP2,
    input  logic              CFG_MSB_FIRST,
    output logic              TX_OUT,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    tx_state_e         r_state, w_state_nxt;
    logic [DW_MAX-1:0] r_buf_data, r_data;
    frame_cfg_t        r_buf_cfg, r_cfg;
    logic              r_buf_full;
    logic [LEN_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_stop_cnt, w_stop_cnt_nxt;
    logic              r_tx, w_tx_nxt;
    logic              r_frame_done;
    logic              w_launch, w_done, w_accept, w_parity, w_data_bit;
    logic [LEN_W-1:0]  w_cfg_len, w_len, w_last, w_bit_idx;

    // Out-of-range lengths are normalised once at capture time.
    assign w_cfg_len = (CFG_LEN == '0 || CFG_LEN > LEN_W'(DW_MAX)) ? LEN_W'(DW_MAX) : CFG_LEN;
    assign w_len     = LEN_W'(r_cfg.len);
    assign w_last    = w_len - LEN_W'(1);
    assign w_accept  = DATA_VALID && !r_buf_full;

    uart_parity_calc #(
        .DW_MAX (DW_MAX),
        .LEN_W  (LEN_W)
    ) u_parity (
        .i_data   (r_data),
        .i_len    (w_len),
        .i_odd    (r_cfg.par_odd),
        .o_parity (w_parity)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_launch       = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_buf_full) begin
                    w_state_nxt = START;
                    w_launch    = 1'b1;
                end
            end
            START: begin
                w_state_nxt   = DATA;
                w_bit_cnt_nxt = '0;
            end
            DATA: begin
                if (r_bit_cnt == w_last) begin
                    if (r_cfg.par_en) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_state_nxt    = STOP;
                        w_stop_cnt_nxt = 1'b0;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + LEN_W'(1);
                end
            end
            PARITY: begin
                w_state_nxt    = STOP;
                w_stop_cnt_nxt = 1'b0;
            end
            STOP: begin
                if (r_cfg.stop2 && !r_stop_cnt) begin
                    w_stop_cnt_nxt = 1'b1;
                end else begin
                    w_done = 1'b1;
                    if (r_buf_full) begin
                        w_state_nxt = START;
                        w_launch    = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The line level is computed for the state being entered so it registers on the same edge.
    assign w_bit_idx  = r_cfg.msb_first ? (w_last - w_bit_cnt_nxt) : w_bit_cnt_nxt;
    assign w_data_bit = |(r_data & (DW_MAX'(1) << w_bit_idx));

    always_comb begin
        w_tx_nxt = STOP_BIT;
        case (w_state_nxt)
            START:   w_tx_nxt = START_BIT;
            DATA:    w_tx_nxt = w_data_bit;
            PARITY:  w_tx_nxt = w_parity;
            default: w_tx_nxt = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_tx         <= STOP_BIT;
            r_frame_done <= 1'b0;
            r_data       <= '0;
            r_cfg        <= '0;
        end else begin
            r_frame_done <= BAUD_EN && w_done;
            if (BAUD_EN) begin
                r_state    <= w_state_nxt;
                r_bit_cnt  <= w_bit_cnt_nxt;
                r_stop_cnt <= w_stop_cnt_nxt;
                r_tx       <= w_tx_nxt;
                if (w_launch) begin
                    r_data <= r_buf_data;
                    r_cfg  <= r_buf_cfg;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
            r_buf_cfg  <= '0;
        end else if (w_accept) begin
            r_buf_full          <= 1'b1;
            r_buf_data          <= P_DATA;
            r_buf_cfg.len       <= CFG_LEN_W'(w_cfg_len);
            r_buf_cfg.par_en    <= CFG_PAR_EN;
            r_buf_cfg.par_odd   <= CFG_PAR_ODD;
            r_buf_cfg.stop2     <= CFG_STOP2;
            r_buf_cfg.msb_first <= CFG_MSB_FIRST;
        end else if (BAUD_EN && w_launch) begin
            r_buf_full <= 1'b0;
        end
    end

    assign TX_OUT     = r_tx;
    assign DATA_READY = !r_buf_full;
    assign BUSY       = (r_state != IDLE);
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench for uart_tx_frame_serializer: frames are modelled as bit lists
// when offered, and a line monitor pops and compares them as they appear on TX_OUT.
module tb_uart_tx_frame_serializer;

    logic       CLK, RST, BAUD_EN, DATA_VALID, DATA_READY;
    logic [7:0] P_DATA;
    logic [3:0] CFG_LEN;
    logic       CFG_PAR_EN, CFG_PAR_ODD, CFG_STOP2, CFG_MSB_FIRST;
    logic       TX_OUT, BUSY, FRAME_DONE;

    uart_tx_frame_serializer #(.DW_MAX(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .BAUD_EN       (BAUD_EN),
        .P_DATA        (P_DATA),
        .DATA_VALID    (DATA_VALID),
        .DATA_READY    (DATA_READY),
        .CFG_LEN       (CFG_LEN),
        .CFG_PAR_EN    (CFG_PAR_EN),
        .CFG_PAR_ODD   (CFG_PAR_ODD),
        .CFG_STOP2     (CFG_STOP2),
        .CFG_MSB_FIRST (CFG_MSB_FIRST),
        .TX_OUT        (TX_OUT),
        .BUSY          (BUSY),
        .FRAME_DONE    (FRAME_DONE)
    );

    typedef struct {
        logic [31:0] bits;
        int          n;
    } frame_t;

    frame_t sb[$];
    int checks = 0, failures = 0;
    int exp_done = 0, done_count = 0, starts = 0, b2b = 0;
    int mon_k = 0;
    bit in_frame = 0, done_pending = 0;
    int baud_div = 1, baud_cnt = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        BAUD_EN = 1;
        forever begin
            @(negedge CLK);
            if (baud_div <= 1) begin
                BAUD_EN = 1;
            end else begin
                BAUD_EN  = (baud_cnt == 0);
                baud_cnt = (baud_cnt + 1) % baud_div;
            end
        end
    end

    // Frame as seen on the line: start, len data bits, optional parity, stop bit(s).
    function automatic frame_t build_frame(logic [7:0] d, logic [3:0] cl, bit pe, bit po, bit s2, bit msb);
        frame_t f;
        int L, ones;
        L = (cl == 0 || cl > 8) ? 8 : int'(cl);
        f.bits = '1;
        f.n = 0;
        f.bits[f.n] = 1'b0; f.n++;
        ones = 0;
        for (int i = 0; i < L; i++) begin
            f.bits[f.n] = msb ? d[L-1-i] : d[i];
            f.n++;
            ones += int'(d[i]);
        end
        if (pe) begin
            f.bits[f.n] = ((ones % 2) == 1) ^ po;
            f.n++;
        end
        f.bits[f.n] = 1'b1; f.n++;
        if (s2) begin
            f.bits[f.n] = 1'b1; f.n++;
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: one sample per baud tick, frames begin on a low start bit.
    initial begin
        frame_t cur;
        logic   b;
        bit     just_done;
        forever begin
            @(posedge CLK);
            b = BAUD_EN;
            #1;
            if (!RST) begin
                in_frame = 0;
                done_pending = 0;
                continue;
            end
            if (FRAME_DONE === 1'b1 && !(b && done_pending)) begin
                failures++;
                $display("FAIL frame_done_spurious: got 1 expected 0 at %0t", $time);
            end
            if (b) begin
                just_done = 0;
                if (done_pending) begin
                    checks++;
                    if (FRAME_DONE !== 1'b1) begin
                        failures++;
                        $display("FAIL frame_done_pulse: got %b expected 1 at %0t", FRAME_DONE, $time);
                    end else begin
                        done_count++;
                    end
                    done_pending = 0;
                    just_done = 1;
                end
                if (in_frame) begin
                    checks++;
                    if (TX_OUT !== cur.bits[mon_k]) begin
                        failures++;
                        $display("FAIL tx_bit[%0d]: got %b expected %b at %0t", mon_k, TX_OUT, cur.bits[mon_k], $time);
                    end
                    mon_k++;
                    if (mon_k == cur.n) begin
                        in_frame = 0;
                        done_pending = 1;
                    end
                end else if (TX_OUT === 1'b0) begin
                    starts++;
                    if (just_done) b2b++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame: got start bit expected idle at %0t", $time);
                    end else begin
                        cur = sb.pop_front();
                        mon_k = 1;
                        in_frame = 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] cl, input bit pe, input bit po,
                        input bit s2, input bit msb);
        bit ok;
        ok = 0;
        @(negedge CLK);
        P_DATA = d; CFG_LEN = cl; CFG_PAR_EN = pe; CFG_PAR_ODD = po;
        CFG_STOP2 = s2; CFG_MSB_FIRST = msb;
        DATA_VALID = 1;
        for (int t = 0; t < 300; t++) begin
            if (DATA_READY) begin
                @(posedge CLK);
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (ok) begin
            sb.push_back(build_frame(d, cl, pe, po, s2, msb));
            exp_done++;
        end else begin
            failures++;
            $display("FAIL handshake_timeout: got no ready expected ready");
        end
        @(negedge CLK);
        DATA_VALID = 0;
        P_DATA = 8'($urandom);
        CFG_LEN = 4'($urandom);
        CFG_PAR_EN = 1'($urandom); CFG_PAR_ODD = 1'($urandom);
        CFG_STOP2 = 1'($urandom); CFG_MSB_FIRST = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !in_frame && !done_pending && !BUSY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        chk("frame_done_count", done_count, exp_done);
    endtask

    initial begin
        int cnt, s0, b0, mism, dn;
        bit ok;
        frame_t f;
        RST = 0; DATA_VALID = 0; P_DATA = 0; CFG_LEN = 0;
        CFG_PAR_EN = 0; CFG_PAR_ODD = 0; CFG_STOP2 = 0; CFG_MSB_FIRST = 0;
        repeat (3) @(negedge CLK);
        chk("rst_tx", TX_OUT, 1);
        chk("rst_ready", DATA_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", FRAME_DONE, 0);
        RST = 1;
        repeat (2) @(negedge CLK);

        // 8N1 0xA5, busy exactly 10 cycles
        send(8'hA5, 4'd8, 0, 0, 0, 0);
        cnt = 0;
        repeat (25) begin
            @(negedge CLK);
            if (BUSY) cnt++;
        end
        chk("busy_cycles_8n1", cnt, 10);
        wait_idle();

        // 7E2 MSB-first 0x41
        send(8'h41, 4'd7, 1, 0, 1, 1);
        wait_idle();

        // back-to-back 0x00 then 0xFF
        s0 = starts; b0 = b2b;
        send(8'h00, 4'd8, 0, 0, 0, 0);
        send(8'hFF, 4'd8, 0, 0, 0, 0);
        chk("ready_low_buffered", DATA_READY, 0);
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (DATA_READY) begin ok = 1; break; end
        end
        chk("ready_rise_seen", ok, 1);
        chk("ready_rise_at_launch", starts, s0 + 2);
        chk("second_start_on_line", TX_OUT, 0);
        chk("b2b_no_gap", b2b, b0 + 1);
        wait_idle();

        // baud 1-in-4, each bit 4 cycles, FRAME_DONE one cycle
        baud_div = 4; baud_cnt = 0;
        send(8'h5A, 4'd8, 0, 0, 0, 0);
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            if (TX_OUT === 1'b0) begin ok = 1; break; end
            @(negedge CLK);
        end
        chk("slow_start_seen", ok, 1);
        f = build_frame(8'h5A, 4'd8, 0, 0, 0, 0);
        mism = 0; dn = 0;
        for (int c = 0; c < 48; c++) begin
            if (c < 40 && TX_OUT !== f.bits[c/4]) begin
                if (mism == 0) $display("FAIL slow_bit cycle %0d: got %b expected %b", c, TX_OUT, f.bits[c/4]);
                mism++;
            end
            if (FRAME_DONE) dn++;
            @(negedge CLK);
        end
        chk("slow_bit_mismatches", mism, 0);
        chk("slow_done_width", dn, 1);
        wait_idle();
        baud_div = 1;

        // len 5 odd parity, then len 0 behaving as 8
        send(8'hFF, 4'd5, 1, 1, 0, 0);
        wait_idle();
        send(8'hFF, 4'd0, 1, 1, 0, 0);
        wait_idle();
        send(8'h3C, 4'd12, 1, 0, 0, 1);
        wait_idle();

        // randomized frames with random baud rate and gaps
        for (int i = 0; i < 30; i++) begin
            baud_div = $urandom_range(1, 3);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end
        wait_idle();
        baud_div = 1;

        // reset during third data bit with a second frame buffered
        send(8'hC3, 4'd8, 0, 0, 0, 0);
        send(8'h96, 4'd8, 1, 0, 1, 0);
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            if (in_frame && mon_k == 4) begin ok = 1; break; end
            @(negedge CLK);
        end
        chk("reset_point_reached", ok, 1);
        s0 = starts;
        #2 RST = 0;
        #1;
        chk("midrst_tx", TX_OUT, 1);
        chk("midrst_ready", DATA_READY, 1);
        chk("midrst_busy", BUSY, 0);
        sb.delete();
        exp_done -= 2;
        repeat (3) @(negedge CLK);
        RST = 1;
        cnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (TX_OUT !== 1'b1) cnt++;
        end
        chk("post_rst_line_idle", cnt, 0);
        chk("post_rst_no_start", starts, s0);
        chk("post_rst_done_count", done_count, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
